led_scheduler: RTL and testbench

LED_SCHEDULER -- requirements
Module: led_scheduler

---
 rtl/led_scheduler.sv | 173 +++++++++++++++++
 tb/tb_led_scheduler.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_scheduler.sv
// led_scheduler: round-robin 3-channel display scheduler with a
// prescaled scan strobe and a 16-bit to 4-digit BCD converter.
// Ports: clk, rst (async, active high); req[2:0] channel requests;
// num0..num2 channel values; scan_tick digit strobe; sel channel shown;
// bcd four BCD digits; blank no channel shown; busy conversion running.
module led_scheduler #(
  parameter int SCAN_DIV    = 50000,
  parameter int DWELL_TICKS = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req,
  input  logic [15:0] num0,
  input  logic [15:0] num1,
  input  logic [15:0] num2,
  output logic        scan_tick,
  output logic [1:0]  sel,
  output logic [15:0] bcd,
  output logic        blank,
  output logic        busy
);

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DWELL_MAX = DW'(DWELL_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  logic [PW-1:0] presc_q, presc_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [1:0]    sel_q, sel_d;
  logic          blank_q, blank_d;
  logic [15:0]   bcd_q, bcd_d;
  logic [31:0]   work_q, work_d;
  logic [4:0]    cnt_q, cnt_d;
  logic          pend_q, pend_d;
  state_t        st_q, st_d;

  logic        expiry;
  logic        adv;
  logic        sel_chg;
  logic        trig;
  logic [1:0]  c1, c2, found;
  logic [15:0] num_sel, num_sat;

  function automatic logic [1:0] inc3(input logic [1:0] s);
    return (s == 2'd2) ? 2'd0 : s + 2'd1;
  endfunction

  // One double-dabble step: fix up BCD nibbles, then shift.
  function automatic logic [31:0] dabble(input logic [31:0] w);
    logic [31:0] t;
    t = w;
    for (int i = 0; i < 4; i++) begin
      if (t[16+4*i +: 4] >= 4'd5)
        t[16+4*i +: 4] = t[16+4*i +: 4] + 4'd3;
    end
    return {t[30:0], 1'b0};
  endfunction

  assign scan_tick = (presc_q == PRESC_MAX);
  assign expiry    = scan_tick && (dwell_q == DWELL_MAX);

  assign c1 = inc3(sel_q);
  assign c2 = inc3(c1);

  // Search sel+1, sel+2, then sel itself; hold if nothing requests.
  always_comb begin
    found = sel_q;
    if (req[c1])
      found = c1;
    else if (req[c2])
      found = c2;
  end

  // Leave early if the shown channel dropped its request.
  assign adv     = expiry || (!req[sel_q] && (req != 3'b000));
  assign sel_d   = adv ? found : sel_q;
  assign sel_chg = (sel_d != sel_q);
  assign blank_d = ~req[sel_q];
  assign trig    = sel_chg || (scan_tick && !blank_q);

  assign presc_d = scan_tick ? '0 : presc_q + 1'b1;

  always_comb begin
    dwell_d = dwell_q;
    if (sel_chg || expiry)
      dwell_d = '0;
    else if (scan_tick)
      dwell_d = dwell_q + 1'b1;
  end

  // Capture uses the channel being selected on this edge.
  always_comb begin
    unique case (sel_d)
      2'd0:    num_sel = num0;
      2'd1:    num_sel = num1;
      default: num_sel = num2;
    endcase
  end

  assign num_sat = (num_sel > 16'd9999) ? 16'd9999 : num_sel;

  always_comb begin
    st_d   = st_q;
    work_d = work_q;
    cnt_d  = cnt_q;
    pend_d = pend_q;
    bcd_d  = bcd_q;
    unique case (st_q)
      IDLE: begin
        if (trig || pend_q) begin
          work_d = {16'd0, num_sat};
          cnt_d  = 5'd0;
          pend_d = 1'b0;
          st_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (trig)
          pend_d = 1'b1;
        if (cnt_q == 5'd16) begin
          st_d = DONE;
        end else begin
          work_d = dabble(work_q);
          cnt_d  = cnt_q + 5'd1;
        end
      end
      DONE: begin
        if (trig)
          pend_d = 1'b1;
        bcd_d = work_q[31:16];
        st_d  = IDLE;
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      dwell_q <= '0;
      sel_q   <= 2'd0;
      blank_q <= 1'b1;
      bcd_q   <= 16'd0;
      work_q  <= 32'd0;
      cnt_q   <= 5'd0;
      pend_q  <= 1'b0;
      st_q    <= IDLE;
    end else begin
      presc_q <= presc_d;
      dwell_q <= dwell_d;
      sel_q   <= sel_d;
      blank_q <= blank_d;
      bcd_q   <= bcd_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      st_q    <= st_d;
    end
  end

  assign sel   = sel_q;
  assign blank = blank_q;
  assign bcd   = bcd_q;
  assign busy  = (st_q != IDLE);

endmodule

// File: tb/tb_led_scheduler.sv
// tb_led_scheduler: scenario tasks plus randomized traffic checked
// against a behavioural model of the scheduler and converter.
module tb_led_scheduler;

  localparam int SD = 4;
  localparam int DT = 3;
  localparam logic [20:0] RST_VEC = {1'b0, 2'd0, 16'd0, 1'b1, 1'b0};

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req;
  logic [15:0] num0, num1, num2;
  logic        scan_tick;
  logic [1:0]  sel;
  logic [15:0] bcd;
  logic        blank;
  logic        busy;
  wire  [20:0] obs = {scan_tick, sel, bcd, blank, busy};

  int n_cmp = 0;
  int n_bad = 0;

  int          m_presc, m_dwell, m_sel, m_edges;
  bit          m_blank, m_active, m_pend;
  logic [15:0] m_bcd, m_cap;

  led_scheduler #(.SCAN_DIV(SD), .DWELL_TICKS(DT)) dut (
    .clk(clk), .rst(rst), .req(req),
    .num0(num0), .num1(num1), .num2(num2),
    .scan_tick(scan_tick), .sel(sel), .bcd(bcd),
    .blank(blank), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int v);
    int s;
    s = (v > 9999) ? 9999 : v;
    return {4'(s / 1000), 4'((s / 100) % 10),
            4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  function automatic int numof(input int c);
    if (c == 0) return int'(num0);
    if (c == 1) return int'(num1);
    return int'(num2);
  endfunction

  function automatic logic [20:0] expv();
    return {m_presc == SD - 1, 2'(m_sel), m_bcd, m_blank, m_active};
  endfunction

  task automatic m_reset();
    m_presc = 0; m_dwell = 0; m_sel = 0; m_edges = 0;
    m_blank = 1; m_active = 0; m_pend = 0;
    m_bcd = 16'd0; m_cap = 16'd0;
  endtask

  // One rising edge of the reference behaviour, from pre-edge inputs.
  task automatic model_edge();
    bit tick, expd, trig, hit;
    int nsel;
    if (rst) begin
      m_reset();
      return;
    end
    tick = (m_presc == SD - 1);
    expd = tick && (m_dwell == DT - 1);
    nsel = m_sel;
    hit  = 0;
    if (expd || (!req[m_sel] && req != 3'b000)) begin
      for (int k = 1; k <= 3; k++) begin
        if (!hit && req[(m_sel + k) % 3]) begin
          nsel = (m_sel + k) % 3;
          hit  = 1;
        end
      end
    end
    trig = (nsel != m_sel) || (tick && !m_blank);
    if (m_active) begin
      if (trig) m_pend = 1;
      m_edges++;
      if (m_edges == 18) begin
        m_bcd    = m_cap;
        m_active = 0;
      end
    end else if (trig || m_pend) begin
      m_cap    = to_bcd(numof(nsel));
      m_active = 1;
      m_edges  = 0;
      m_pend   = 0;
    end
    if (nsel != m_sel || expd) m_dwell = 0;
    else if (tick) m_dwell++;
    m_blank = !req[m_sel];
    m_sel   = nsel;
    m_presc = (m_presc + 1) % SD;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if (obs !== RST_VEC) begin
      n_bad++;
      $display("FAIL reset_async got %h want %h", obs, RST_VEC);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (obs !== RST_VEC) begin
        n_bad++;
        $display("FAIL reset_hold got %h want %h", obs, RST_VEC);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_idle_scan();
    int ticks = 0;
    req = 3'b000;
    for (int i = 0; i < 16; i++) begin
      step();
      ticks += int'(scan_tick);
      n_cmp++;
      if (obs !== expv()) begin
        n_bad++;
        $display("FAIL idle_scan got %h want %h", obs, expv());
      end
    end
    n_cmp++;
    if (ticks !== 4) begin
      n_bad++;
      $display("FAIL idle_tick_count got %0d want 4", ticks);
    end
  endtask

  task automatic test_single();
    int cap = -1;
    int done = -1;
    req  = 3'b001;
    num0 = 16'd1234;
    for (int i = 0; i < 60 && done < 0; i++) begin
      step();
      n_cmp++;
      if (obs !== expv()) begin
        n_bad++;
        $display("FAIL single got %h want %h", obs, expv());
      end
      if (cap < 0 && busy === 1'b1) cap = i;
      if (bcd === 16'h1234) done = i;
    end
    n_cmp++;
    if (bcd !== 16'h1234) begin
      n_bad++;
      $display("FAIL single_value got %h want 1234", bcd);
    end
    n_cmp++;
    if (cap < 0 || done - cap !== 18) begin
      n_bad++;
      $display("FAIL single_latency got %0d want 18", done - cap);
    end
  endtask

  task automatic test_round_robin();
    int last = -1;
    int nchg = 0;
    logic [1:0] prev;
    req  = 3'b111;
    num0 = 16'd5;
    num1 = 16'd60;
    num2 = 16'd700;
    prev = sel;
    for (int i = 0; i < 64; i++) begin
      step();
      n_cmp++;
      if (obs !== expv()) begin
        n_bad++;
        $display("FAIL rr got %h want %h", obs, expv());
      end
      if (sel !== prev) begin
        n_cmp++;
        if (sel !== 2'((int'(prev) + 1) % 3)) begin
          n_bad++;
          $display("FAIL rr_order got %0d want %0d", sel,
                   (int'(prev) + 1) % 3);
        end
        if (nchg > 0) begin
          n_cmp++;
          if (i - last !== 12) begin
            n_bad++;
            $display("FAIL rr_dwell got %0d want 12", i - last);
          end
        end
        last = i;
        nchg++;
        prev = sel;
      end
    end
    n_cmp++;
    if (nchg < 4) begin
      n_bad++;
      $display("FAIL rr_changes got %0d want >=4", nchg);
    end
  endtask

  task automatic test_saturate();
    logic [15:0] vals [3];
    logic [15:0] want [3];
    vals[0] = 16'd65535; want[0] = 16'h9999;
    vals[1] = 16'd0;     want[1] = 16'h0000;
    vals[2] = 16'd10000; want[2] = 16'h9999;
    req = 3'b010;
    for (int v = 0; v < 3; v++) begin
      num1 = vals[v];
      for (int i = 0; i < 80; i++) begin
        step();
        n_cmp++;
        if (obs !== expv()) begin
          n_bad++;
          $display("FAIL sat got %h want %h", obs, expv());
        end
      end
      n_cmp++;
      if (bcd !== want[v] || sel !== 2'd1) begin
        n_bad++;
        $display("FAIL sat_value got %h want %h", bcd, want[v]);
      end
    end
  endtask

  task automatic test_preempt();
    req = 3'b101;
    for (int i = 0; i < 60; i++) begin
      step();
      n_cmp++;
      if (obs !== expv()) begin
        n_bad++;
        $display("FAIL preempt got %h want %h", obs, expv());
      end
      if (sel === 2'd0 && i > 0) break;
    end
    n_cmp++;
    if (sel !== 2'd0) begin
      n_bad++;
      $display("FAIL preempt_wait got %0d want 0", sel);
    end
    req = 3'b100;
    step();
    n_cmp++;
    if (sel !== 2'd2 || obs !== expv()) begin
      n_bad++;
      $display("FAIL preempt_sel got %0d want 2", sel);
    end
  endtask

  task automatic test_reset_abort();
    logic pb;
    bit seen = 0;
    req  = 3'b100;
    num2 = 16'd777;
    pb   = busy;
    for (int i = 0; i < 60 && !seen; i++) begin
      step();
      n_cmp++;
      if (obs !== expv()) begin
        n_bad++;
        $display("FAIL abort_pre got %h want %h", obs, expv());
      end
      if (pb === 1'b0 && busy === 1'b1) seen = 1;
      pb = busy;
    end
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL abort_start got 0 want 1");
    end
    repeat (7) step();
    rst = 1'b1;
    m_reset();
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if (obs !== RST_VEC) begin
        n_bad++;
        $display("FAIL abort_rst got %h want %h", obs, RST_VEC);
      end
      step();
    end
    rst  = 1'b0;
    req  = 3'b010;
    num1 = 16'd42;
    for (int i = 0; i < 80 && bcd === 16'd0; i++) begin
      step();
      n_cmp++;
      if (obs !== expv()) begin
        n_bad++;
        $display("FAIL abort_post got %h want %h", obs, expv());
      end
    end
    n_cmp++;
    if (bcd !== 16'h0042) begin
      n_bad++;
      $display("FAIL abort_value got %h want 0042", bcd);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) req = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 5) == 0) begin
        logic [15:0] v;
        v = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 12000))
                                        : 16'($urandom);
        case ($urandom_range(0, 2))
          0: num0 = v;
          1: num1 = v;
          default: num2 = v;
        endcase
      end
      step();
      n_cmp++;
      if (obs !== expv()) begin
        n_bad++;
        $display("FAIL random got %h want %h", obs, expv());
      end
    end
  endtask

  initial begin
    rst  = 1'b1;
    req  = 3'b000;
    num0 = 16'd0;
    num1 = 16'd0;
    num2 = 16'd0;
    m_reset();
    test_reset();
    test_idle_scan();
    test_single();
    test_round_robin();
    test_saturate();
    test_preempt();
    test_reset_abort();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
